// File: rtl/thermo_lane_serializer_if.sv
// Word-in / lane-out handshake bundle for the thermometer lane serializer.
// The slave side is the serializer; the master side drives words and takes beats.
interface thermo_lane_serializer_if #(
  parameter int M = 8,
  parameter int W = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [M*W-1:0]   i_data;
  logic [M-1:0]     i_thermo;
  logic             i_vf;
  logic             o_valid;
  logic             i_ready;
  logic [W-1:0]     o_data;
  logic             o_last;
  logic             o_err;
  logic             o_busy;

  modport slave (
    input  i_valid, i_data, i_thermo, i_vf, i_ready,
    output o_ready, o_valid, o_data, o_last, o_err, o_busy
  );

  modport master (
    output i_valid, i_data, i_thermo, i_vf, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_err, o_busy
  );
endinterface

// File: rtl/thermo_lane_serializer.sv
// Serializes the thermometer-masked lanes of one word, lane 0 first, one per beat.
// Malformed masks and overflowed lengths are dropped with a one-cycle error pulse.
module thermo_lane_serializer #(
  parameter int M = 8,
  parameter int W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  thermo_lane_serializer_if.slave    bus
);

  localparam int CW = $clog2(M + 1);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [M-1:0][W-1:0]    lanes_q, lanes_d;
  logic                   valid_q, valid_d;
  logic [W-1:0]           odata_q, odata_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;

  logic [M:0]             t_ext;
  logic                   mask_ok;
  logic [CW-1:0]          in_cnt;
  logic [IW-1:0]          nxt_idx;
  logic [M-1:0][W-1:0]    in_lanes;

  function automatic logic [CW-1:0] popcnt(input logic [M-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < M; k++) c = c + CW'(v[k]);
    return c;
  endfunction

  // 2^n-1 masks are exactly those where adding one clears every set bit.
  assign t_ext    = {1'b0, bus.i_thermo};
  assign mask_ok  = ((t_ext & (t_ext + (M+1)'(1))) == '0);
  assign in_cnt   = popcnt(bus.i_thermo);
  assign nxt_idx  = idx_q + IW'(1);
  assign in_lanes = bus.i_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    valid_d = valid_q;
    odata_d = odata_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        odata_d = '0;
        last_d  = 1'b0;
        if (bus.i_valid) begin
          if (bus.i_vf || !mask_ok) begin
            err_d = 1'b1;
          end else if (bus.i_thermo != '0) begin
            lanes_d = in_lanes;
            cnt_d   = in_cnt;
            idx_d   = '0;
            state_d = SEND;
            // Outputs are registered, so the first beat is loaded at accept.
            valid_d = 1'b1;
            odata_d = in_lanes[0];
            last_d  = (in_cnt == CW'(1));
          end
        end
      end
      SEND: begin
        if (bus.i_ready) begin
          if (last_q) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            odata_d = '0;
            last_d  = 1'b0;
          end else begin
            idx_d   = nxt_idx;
            odata_d = lanes_q[nxt_idx];
            last_d  = (CW'(nxt_idx) == cnt_q - CW'(1));
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        odata_d = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
      odata_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
      valid_q <= valid_d;
      odata_q <= odata_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_busy  = (state_q == SEND);
  assign bus.o_valid = valid_q;
  assign bus.o_data  = odata_q;
  assign bus.o_last  = last_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_thermo_lane_serializer.sv
// Directed bench for thermo_lane_serializer: lane order, stalls, zero-length,
// rejected words and mid-word reset.
module tb_thermo_lane_serializer;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  thermo_lane_serializer_if #(.M(8), .W(8)) bus ();

  thermo_lane_serializer #(.M(8), .W(8)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Offer one word and drain it; stall=1 drives i_ready as 1,0,0 repeating.
  task automatic run_word(input logic [63:0] d, input logic [7:0] t, input int n, input bit stall);
    int beat;
    int cyc;
    bit rdy;
    bus.i_data   = d;
    bus.i_thermo = t;
    bus.i_vf     = 1'b0;
    bus.i_valid  = 1'b1;
    bus.i_ready  = 1'b1;
    tick();
    bus.i_valid  = 1'b0;
    bus.i_data   = 64'hDEAD_BEEF_0BAD_F00D;
    bus.i_thermo = 8'h3;
    beat = 0;
    cyc  = 0;
    while (beat < n && cyc < 64) begin
      chk("beat_valid", bus.o_valid, 1);
      chk("beat_busy",  bus.o_busy, 1);
      chk("beat_ready", bus.o_ready, 0);
      chk("beat_data",  bus.o_data, d[beat*8 +: 8]);
      chk("beat_last",  bus.o_last, (beat == n-1));
      chk("beat_err",   bus.o_err, 0);
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      bus.i_ready = rdy;
      if (rdy) beat++;
      cyc++;
      tick();
    end
    chk("beat_count", beat, n);
    chk("end_valid",  bus.o_valid, 0);
    chk("end_busy",   bus.o_busy, 0);
    chk("end_ready",  bus.o_ready, 1);
    chk("end_data",   bus.o_data, 0);
    chk("end_last",   bus.o_last, 0);
    bus.i_ready = 1'b1;
  endtask

  // A word that must produce exactly a one-cycle o_err (or nothing, for zero-length).
  task automatic reject_word(input logic [7:0] t, input bit vf, input bit exp_err);
    bus.i_data   = 64'h0807060504030201;
    bus.i_thermo = t;
    bus.i_vf     = vf;
    bus.i_valid  = 1'b1;
    bus.i_ready  = 1'b1;
    tick();
    bus.i_valid  = 1'b0;
    bus.i_vf     = 1'b0;
    chk("rej_err",   bus.o_err, exp_err);
    chk("rej_valid", bus.o_valid, 0);
    chk("rej_ready", bus.o_ready, 1);
    chk("rej_busy",  bus.o_busy, 0);
    tick();
    chk("rej_err_drop", bus.o_err, 0);
    chk("rej_valid2",   bus.o_valid, 0);
    chk("rej_ready2",   bus.o_ready, 1);
  endtask

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    bus.i_thermo = '0;
    bus.i_vf     = 1'b0;
    bus.i_ready  = 1'b1;
    #2;
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_busy",  bus.o_busy, 0);
    chk("rst_err",   bus.o_err, 0);
    chk("rst_data",  bus.o_data, 0);
    chk("rst_last",  bus.o_last, 0);
    tick();
    i_rst = 1'b0;
    tick();

    run_word(64'h0807060504030201, 8'h07, 3, 1'b0);
    run_word(64'h0807060504030201, 8'hFF, 8, 1'b1);
    reject_word(8'h00, 1'b0, 1'b0);
    reject_word(8'h05, 1'b0, 1'b1);
    run_word(64'h00000000000000AA, 8'h01, 1, 1'b0);
    reject_word(8'hFF, 1'b1, 1'b1);
    reject_word(8'h80, 1'b0, 1'b1);
    run_word(64'h8877665544332211, 8'h3F, 6, 1'b0);

    // Reset after two beats of a four-lane word must abort it silently.
    bus.i_data   = 64'h0807060504030201;
    bus.i_thermo = 8'h0F;
    bus.i_vf     = 1'b0;
    bus.i_valid  = 1'b1;
    bus.i_ready  = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    chk("abort_b0", bus.o_data, 8'h01);
    tick();
    chk("abort_b1", bus.o_data, 8'h02);
    tick();
    chk("abort_b2_pending", bus.o_data, 8'h03);
    i_rst = 1'b1;
    #1;
    chk("abort_valid", bus.o_valid, 0);
    chk("abort_busy",  bus.o_busy, 0);
    chk("abort_data",  bus.o_data, 0);
    chk("abort_last",  bus.o_last, 0);
    chk("abort_ready", bus.o_ready, 1);
    chk("abort_err",   bus.o_err, 0);
    tick();
    i_rst = 1'b0;
    tick();
    chk("post_rst_valid", bus.o_valid, 0);
    chk("post_rst_err",   bus.o_err, 0);
    run_word(64'h000000000000005C, 8'h01, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
